pll_reset_seq: RTL

Reset/lock sequencer for the video PLL on the ULX3S. It runs on the 25 MHz board clock and drives the PLL reset. It waits for a debounced LOCK, then releases the draw and pixel domain resets in a fixed order. It re-arms on lock loss and retries the PLL if lock does not arrive within a timeout.

---
 rtl/pll_reset_seq_pkg.sv | 27 ++
 rtl/pll_reset_seq_if.sv | 23 ++
 rtl/pll_reset_seq_sync2.sv | 22 ++
 rtl/pll_reset_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and sizing helpers for the video PLL reset/lock sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    REL_DRAW,
    RUN,
    LOSS,
    FAULT
  } state_e;

  localparam int ATTEMPT_W = 4;

  // One timer serves every state, so it must hold the longest interval plus headroom.
  function automatic int timer_width(input int rst_pulse, input int lock_timeout,
                                     input int stable_cycles, input int release_gap);
    int m;
    m = rst_pulse;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (release_gap > m) m = release_gap;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Lock input, retry request and reset/status outputs of the PLL sequencer.
interface pll_reset_seq_if;
  import pll_reset_pkg::*;

  logic                 locked;
  logic                 retry;
  logic                 pll_rst;
  logic                 rst_draw_n;
  logic                 rst_pix_n;
  logic                 ready;
  logic                 fault;
  logic [ATTEMPT_W-1:0] attempts;

  modport master (
    input  locked, retry,
    output pll_rst, rst_draw_n, rst_pix_n, ready, fault, attempts
  );

  modport slave (
    output locked, retry,
    input  pll_rst, rst_draw_n, rst_pix_n, ready, fault, attempts
  );
endinterface

// File: rtl/pll_reset_seq_sync2.sv
// Two-flop synchroniser with synchronous active-low clear to 0.
module sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock, then releases
// the draw domain before the pixel domain; re-arms on lock loss or timeout.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 250,
  parameter int RELEASE_GAP   = 8,
  parameter int MAX_RETRIES   = 7
) (
  input  logic           clkin,
  input  logic           resetn,
  pll_reset_seq_if.master bus
);
  localparam int TIMER_W = timer_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP);

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RST_PULSE - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lk already counts as one stable cycle.
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'((RELEASE_GAP > 0) ? RELEASE_GAP - 1 : 0);
  localparam logic [ATTEMPT_W-1:0] RETRY_LIMIT = ATTEMPT_W'(MAX_RETRIES);

  state_e               state;
  logic [TIMER_W-1:0]   timer;
  logic                 lk;
  logic                 pll_rst;
  logic                 rst_draw_n;
  logic                 rst_pix_n;
  logic                 ready;
  logic                 fault;
  logic [ATTEMPT_W-1:0] attempts;
  logic [ATTEMPT_W-1:0] att_next;

  sync2 u_lock_sync (
    .clk    (clkin),
    .resetn (resetn),
    .d      (bus.locked),
    .q      (lk)
  );

  assign att_next = (attempts == '1) ? attempts : attempts + 1'b1;

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state      <= RESET_PLL;
      timer      <= '0;
      pll_rst    <= 1'b1;
      rst_draw_n <= 1'b0;
      rst_pix_n  <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      attempts   <= '0;
    end else begin
      timer <= timer + 1'b1;
      unique case (state)
        RESET_PLL: begin
          if (timer == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            attempts <= att_next;
            timer    <= '0;
            if (MAX_RETRIES != 0 && att_next >= RETRY_LIMIT) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state   <= RESET_PLL;
              pll_rst <= 1'b1;
            end
          end
        end
        STABLE: begin
          // A dropout here is a glitch, not a failed attempt.
          if (!lk) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state      <= REL_DRAW;
            timer      <= '0;
            rst_draw_n <= 1'b1;
          end
        end
        REL_DRAW: begin
          if (!lk) begin
            state      <= LOSS;
            timer      <= '0;
            rst_draw_n <= 1'b0;
          end else if (timer == GAP_LAST) begin
            state     <= RUN;
            timer     <= '0;
            rst_pix_n <= 1'b1;
            ready     <= 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state      <= LOSS;
            timer      <= '0;
            rst_draw_n <= 1'b0;
            rst_pix_n  <= 1'b0;
            ready      <= 1'b0;
          end else if (bus.retry) begin
            state      <= RESET_PLL;
            timer      <= '0;
            pll_rst    <= 1'b1;
            rst_draw_n <= 1'b0;
            rst_pix_n  <= 1'b0;
            ready      <= 1'b0;
          end
        end
        LOSS: begin
          state   <= RESET_PLL;
          timer   <= '0;
          pll_rst <= 1'b1;
        end
        FAULT: begin
          if (bus.retry) begin
            state    <= RESET_PLL;
            timer    <= '0;
            pll_rst  <= 1'b1;
            fault    <= 1'b0;
            attempts <= '0;
          end
        end
        default: begin
          state      <= RESET_PLL;
          timer      <= '0;
          pll_rst    <= 1'b1;
          rst_draw_n <= 1'b0;
          rst_pix_n  <= 1'b0;
          ready      <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst    = pll_rst;
  assign bus.rst_draw_n = rst_draw_n;
  assign bus.rst_pix_n  = rst_pix_n;
  assign bus.ready      = ready;
  assign bus.fault      = fault;
  assign bus.attempts   = attempts;
endmodule
